// File: rtl/apb_pkg.sv
// Shared definitions for the parametrised APB master.
//   - apb_state_e   : master FSM states
//   - APB_DW/APB_AW : bus data/address widths
//   - DEF_*         : default region size and PREADY timeout
//   - DEFAULT_BASES : default region map (0x1000_0000 + i*0x1000) for up to
//                     MAX_SLAVES slaves; callers slice the low entries they need
package apb_pkg;

    localparam int APB_DW              = 32;
    localparam int APB_AW              = 32;
    localparam int MAX_SLAVES          = 16;
    localparam int DEF_REGION_BITS     = 12;
    localparam int DEF_TIMEOUT_CYCLES  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } apb_state_e;

    function automatic logic [MAX_SLAVES-1:0][APB_AW-1:0] gen_default_bases();
        logic [MAX_SLAVES-1:0][APB_AW-1:0] bases;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            bases[i] = 32'h1000_0000 + (32'(i) << 12);
        end
        return bases;
    endfunction

    localparam logic [MAX_SLAVES-1:0][APB_AW-1:0] DEFAULT_BASES = gen_default_bases();

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational region decoder.
//   addr : byte address from the core
//   sel  : one-hot slave select (all zero on a miss)
//   hit  : at least one region matched
//   idx  : encoded index of the selected slave
// Only addr[APB_AW-1:REGION_BITS] takes part in the compare; when regions
// overlap the lowest slave index wins.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES  = 5,
    parameter int REGION_BITS = DEF_REGION_BITS,
    parameter logic [NUM_SLAVES-1:0][APB_AW-1:0] BASE_ADDR = DEFAULT_BASES[NUM_SLAVES-1:0],
    parameter int IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [APB_AW-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    // Offset bits inside a region never influence the decode.
    logic unused_offset;
    assign unused_offset = ^addr[REGION_BITS-1:0];

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        sel = '0;
        hit = 1'b0;
        idx = '0;
        // Scan from the top down so a lower matching index overwrites a higher one.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (addr[APB_AW-1:REGION_BITS] == BASE_ADDR[i][APB_AW-1:REGION_BITS]) begin
                hit    = 1'b1;
                idx    = IDX_W'(i);
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_mp.sv
// APB master bridging the core's data port to NUM_SLAVES peripherals.
//   Core side : transfer/write/addr/wdata/strb request (sampled in IDLE only),
//               ready/err/rdata one-cycle completion response
//   APB side  : PADDR/PWDATA/PWRITE/PSTRB/PSEL/PENABLE out,
//               PRDATA/PREADY/PSLVERR in, one lane per slave
// A decode miss completes one cycle after acceptance with err=1. A slave that
// holds PREADY low for TIMEOUT_CYCLES access cycles is abandoned with err=1.
module apb_master_mp
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES     = 5,
    parameter int REGION_BITS    = DEF_REGION_BITS,
    parameter logic [NUM_SLAVES-1:0][APB_AW-1:0] BASE_ADDR = DEFAULT_BASES[NUM_SLAVES-1:0],
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              PCLK,
    input  logic                              PRESET,
    input  logic                              transfer,
    input  logic                              write,
    input  logic [APB_AW-1:0]                 addr,
    input  logic [APB_DW-1:0]                 wdata,
    input  logic [3:0]                        strb,
    output logic                              ready,
    output logic                              err,
    output logic [APB_DW-1:0]                 rdata,
    output logic [APB_AW-1:0]                 PADDR,
    output logic [APB_DW-1:0]                 PWDATA,
    output logic                              PWRITE,
    output logic [3:0]                        PSTRB,
    output logic                              PENABLE,
    output logic [NUM_SLAVES-1:0]             PSEL,
    input  logic [NUM_SLAVES-1:0][APB_DW-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]             PREADY,
    input  logic [NUM_SLAVES-1:0]             PSLVERR
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e              state_q,  state_d;
    logic [APB_AW-1:0]       paddr_q,  paddr_d;
    logic [APB_DW-1:0]       pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic [3:0]              pstrb_q,  pstrb_d;
    logic [NUM_SLAVES-1:0]   sel_oh_q, sel_oh_d;
    logic [IDX_W-1:0]        sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;

    apb_addr_decoder #(
        .NUM_SLAVES  (NUM_SLAVES),
        .REGION_BITS (REGION_BITS),
        .BASE_ADDR   (BASE_ADDR),
        .IDX_W       (IDX_W)
    ) u_decoder (
        .addr (addr),
        .sel  (dec_sel),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        sel_oh_d  = sel_oh_q;
        sel_idx_d = sel_idx_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        err       = 1'b0;
        rdata     = '0;

        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    paddr_d   = addr;
                    pwdata_d  = wdata;
                    pwrite_d  = write;
                    pstrb_d   = write ? strb : 4'b0000;
                    sel_oh_d  = dec_sel;
                    sel_idx_d = dec_idx;
                    cnt_d     = '0;
                    state_d   = dec_hit ? SETUP : DERR;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY[sel_idx_q]) begin
                    ready   = 1'b1;
                    err     = PSLVERR[sel_idx_q];
                    rdata   = pwrite_q ? '0 : PRDATA[sel_idx_q];
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Slave never answered: abandon the access.
                    ready   = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DERR: begin
                ready   = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            pstrb_q   <= '0;
            sel_oh_q  <= '0;
            sel_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            pstrb_q   <= pstrb_d;
            sel_oh_q  <= sel_oh_d;
            sel_idx_q <= sel_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Select/enable come straight from the state flop so an async reset drops
    // them immediately; DERR never drives PSEL.
    assign PSEL    = (state_q == SETUP || state_q == ACCESS) ? sel_oh_q : '0;
    assign PENABLE = (state_q == ACCESS);
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PSTRB   = pstrb_q;

endmodule
